// File: rtl/uart_fifo_pkg.sv
// Shared definitions for the UART <-> frame FIFO controllers.
// State encoding, error codes and default frame parameters.
package uart_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PAYLOAD  = 2'd1,
    CHECKSUM = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_CSUM = 2'd3;

  localparam int          DEF_FRAME_LEN   = 256;
  localparam logic [7:0]  DEF_SYNC_BYTE   = 8'hA5;
  localparam int          DEF_TIMEOUT_CYC = 50000;

endpackage

// File: rtl/rx_timeout_cnt.sv
// Clearable saturating up-counter; expired is high while the count sits at LIMIT.
module rx_timeout_cnt #(
  parameter int LIMIT = 50000
) (
  input  logic rd_clk,
  input  logic rst_n,
  input  logic clr,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

  logic [W-1:0] cnt_q;

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (cnt_q != LIMIT_W) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = (cnt_q == LIMIT_W);

endmodule

// File: rtl/uart_rx_fifo_wr.sv
// Sync-hunting frame writer from uart_rx into the frame FIFO write port.
// Build option: define CHECKSUM_EN to require a trailing additive checksum byte.
//
// state    | meaning
// IDLE     | waiting for SYNC_BYTE, other bytes dropped
// PAYLOAD  | writing FRAME_LEN payload bytes into the FIFO
// CHECKSUM | waiting for the trailing checksum byte
// DONE     | one-cycle good-frame indication
module uart_rx_fifo_wr
  import uart_fifo_pkg::*;
#(
  parameter int         FRAME_LEN   = DEF_FRAME_LEN,
  parameter logic [7:0] SYNC_BYTE   = DEF_SYNC_BYTE,
  parameter int         TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic       rd_clk,
  input  logic       rst_n,
  input  logic       wr_rst_busy,
  input  logic       uart_rx_done,
  input  logic [7:0] uart_rx_data,
  input  logic       full,
  output logic       fifo_wr_en,
  output logic [7:0] fifo_wr_data,
  output logic       frame_received,
  output logic [8:0] write_count,
  output logic       rx_error,
  output logic [1:0] error_code
);

  state_t     state_q, state_d;
  logic       wr_en_d, frame_d, rx_error_d;
  logic [7:0] wr_data_d;
  logic [8:0] count_d;
  logic [1:0] code_d;
  logic       tmo_expired, tmo_clr, last_byte, is_sync;

  assign is_sync   = uart_rx_done && (uart_rx_data == SYNC_BYTE);
  assign last_byte = (write_count == 9'(FRAME_LEN - 1));
  assign tmo_clr   = uart_rx_done || (state_q == IDLE) || (state_q == DONE);

  rx_timeout_cnt #(.LIMIT(TIMEOUT_CYC)) u_tmo (
    .rd_clk (rd_clk),
    .rst_n  (rst_n),
    .clr    (tmo_clr),
    .expired(tmo_expired)
  );

`ifdef CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) csum_q <= '0;
    else        csum_q <= csum_d;
  end
`endif

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (is_sync) state_d = PAYLOAD;
      PAYLOAD: begin
        if (uart_rx_done) begin
          if (full) begin
            state_d = IDLE;
          end else if (last_byte) begin
`ifdef CHECKSUM_EN
            state_d = CHECKSUM;
`else
            state_d = DONE;
`endif
          end
        end else if (tmo_expired) begin
          state_d = IDLE;
        end
      end
      CHECKSUM: begin
`ifdef CHECKSUM_EN
        if (uart_rx_done)     state_d = (uart_rx_data == csum_q) ? DONE : IDLE;
        else if (tmo_expired) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (wr_rst_busy) state_d = IDLE;
  end

  always_comb begin
    wr_en_d    = 1'b0;
    wr_data_d  = fifo_wr_data;
    count_d    = write_count;
    rx_error_d = rx_error;
    code_d     = error_code;
`ifdef CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (is_sync) begin
          count_d    = '0;
          rx_error_d = 1'b0;
          code_d     = ERR_NONE;
`ifdef CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      PAYLOAD: begin
        if (uart_rx_done) begin
          if (full) begin
            rx_error_d = 1'b1;
            code_d     = ERR_OVF;
          end else begin
            wr_en_d   = 1'b1;
            wr_data_d = uart_rx_data;
            count_d   = write_count + 9'd1;
`ifdef CHECKSUM_EN
            csum_d    = csum_q + uart_rx_data;
`endif
          end
        end else if (tmo_expired) begin
          rx_error_d = 1'b1;
          code_d     = ERR_TMO;
        end
      end
      CHECKSUM: begin
`ifdef CHECKSUM_EN
        if (uart_rx_done) begin
          if (uart_rx_data != csum_q) begin
            rx_error_d = 1'b1;
            code_d     = ERR_CSUM;
          end
        end else if (tmo_expired) begin
          rx_error_d = 1'b1;
          code_d     = ERR_TMO;
        end
`endif
      end
      default: ;
    endcase
    // FIFO reset aborts the frame but leaves the error status visible
    if (wr_rst_busy) begin
      wr_en_d    = 1'b0;
      count_d    = '0;
      rx_error_d = rx_error;
      code_d     = error_code;
    end
    frame_d = (state_d == DONE);
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_en     <= 1'b0;
      fifo_wr_data   <= '0;
      frame_received <= 1'b0;
      write_count    <= '0;
      rx_error       <= 1'b0;
      error_code     <= ERR_NONE;
    end else begin
      fifo_wr_en     <= wr_en_d;
      fifo_wr_data   <= wr_data_d;
      frame_received <= frame_d;
      write_count    <= count_d;
      rx_error       <= rx_error_d;
      error_code     <= code_d;
    end
  end

endmodule
